// File: rtl/menu_pkg.sv
// Shared constants, FSM encoding and helpers for the LCD menu command controller.
package menu_pkg;

    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_U = 8'h55;
    localparam logic [7:0] CH_D = 8'h44;
    localparam logic [7:0] CH_H = 8'h48;
    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_9 = 8'h39;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    // UART receive handshake states; IDLE must stay the all-zero encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } uart_state_t;

    // Navigation actions shared by the button path and the byte decoder
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LEFT  = 3'd1,
        CMD_RIGHT = 3'd2,
        CMD_UP    = 3'd3,
        CMD_DOWN  = 3'd4,
        CMD_HOME  = 3'd5,
        CMD_PAGE  = 3'd6,
        CMD_BAD   = 3'd7
    } cmd_t;

    // Index width for a range of n values, never narrower than one bit
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Fold lowercase ASCII letters onto uppercase so both spellings decode alike
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single level signal crossing into clk.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the input through the flop chain; the last stage is the safe copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/menu_cmd_controller.sv
// Menu page/item controller merging debounced buttons and UART command bytes.
// UART commands own the update slot in their CAPTURE cycle; button events wait
// as pending bits and are served one per free cycle.
module menu_cmd_controller
    import menu_pkg::*;
#(
    parameter int N_PAGE      = 4,
    parameter int N_ITEM      = 4,
    parameter int WRAP        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1000,
    parameter int LED_HOLD    = 100000
) (
    input  logic                          clk_1MHz,
    input  logic                          rst_n,
    input  logic                          btn_l,
    input  logic                          btn_r,
    input  logic                          btn_u,
    input  logic                          btn_d,
    input  logic                          uart_rvalid,
    input  logic [7:0]                    uart_rdata,
    output logic                          uart_ren,
    output logic [width_of(N_PAGE)-1:0]   page,
    output logic [width_of(N_ITEM)-1:0]   item,
    output logic                          cmd_err,
    output logic                          uart_act_led,
    output logic                          last_src
);

    localparam int PW = width_of(N_PAGE);
    localparam int IW = width_of(N_ITEM);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int LW = $clog2(LED_HOLD + 1);

    logic          rv_s;
    uart_state_t   state;
    uart_state_t   state_nxt;
    logic [TW-1:0] ack_cnt;
    logic          ack_timeout;
    logic          rearm;
    logic          uart_slot;

    logic [7:0]    up_byte;
    logic [3:0]    digit_val;
    cmd_t          uart_cmd;

    logic [3:0]    btn_now;
    logic [3:0]    btn_prev;
    logic [3:0]    btn_rise;
    logic [3:0]    pending;
    logic [3:0]    serve;
    cmd_t          btn_cmd;

    cmd_t          act;
    logic          act_uart;
    logic [PW-1:0] page_nxt;
    logic [IW-1:0] item_nxt;
    logic          src_nxt;
    logic          err_nxt;
    logic [LW-1:0] led_cnt;

    // Step an index up or down, wrapping or saturating at the range ends
    function automatic int step_idx(input int v, input int n, input logic inc);
        if (inc) begin
            if (v == n - 1) return (WRAP != 0) ? 0 : v;
            return v + 1;
        end
        if (v == 0) return (WRAP != 0) ? n - 1 : 0;
        return v - 1;
    endfunction

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rvalid_sync (
        .clk   (clk_1MHz),
        .rst_n (rst_n),
        .d     (uart_rvalid),
        .q     (rv_s)
    );

    assign uart_slot   = (state == CAPTURE);
    assign ack_timeout = (state == ACK) && rv_s && (ack_cnt == TW'(ACK_TIMEOUT - 1));

    // UART handshake state register
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake transitions; ren is held for the whole ACK state
    always_comb begin
        state_nxt = state;
        uart_ren  = 1'b0;
        case (state)
            IDLE: begin
                if (rv_s && !rearm) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = ACK;
            end
            ACK: begin
                uart_ren = 1'b1;
                if (!rv_s || ack_timeout) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Count ACK cycles spent waiting for rvalid to fall
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt <= '0;
        end else if (state == ACK && rv_s) begin
            ack_cnt <= ack_cnt + TW'(1);
        end else begin
            ack_cnt <= '0;
        end
    end

    // After a timeout, a still-high rvalid is the same byte; wait for it to drop
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            rearm <= 1'b0;
        end else if (ack_timeout) begin
            rearm <= 1'b1;
        end else if (!rv_s) begin
            rearm <= 1'b0;
        end
    end

    assign up_byte = to_upper(uart_rdata);

    // Decode the received byte; rdata is stable while the synchronised rvalid is high
    always_comb begin
        uart_cmd  = CMD_BAD;
        digit_val = '0;
        if (up_byte == CH_L) begin
            uart_cmd = CMD_LEFT;
        end else if (up_byte == CH_R) begin
            uart_cmd = CMD_RIGHT;
        end else if (up_byte == CH_U) begin
            uart_cmd = CMD_UP;
        end else if (up_byte == CH_D) begin
            uart_cmd = CMD_DOWN;
        end else if (up_byte == CH_H) begin
            uart_cmd = CMD_HOME;
        end else if (uart_rdata >= CH_0 && uart_rdata <= CH_9) begin
            digit_val = 4'(uart_rdata - CH_0);
            uart_cmd  = (int'(digit_val) < N_PAGE) ? CMD_PAGE : CMD_BAD;
        end else if (uart_rdata == CR || uart_rdata == LF) begin
            uart_cmd = CMD_NONE;
        end
    end

    assign btn_now  = {btn_d, btn_u, btn_r, btn_l};
    assign btn_rise = btn_now & ~btn_prev;

    // Pick the highest-priority pending button, only when UART is not applying
    always_comb begin
        serve   = '0;
        btn_cmd = CMD_NONE;
        if (!uart_slot) begin
            if (pending[0]) begin
                serve   = 4'b0001;
                btn_cmd = CMD_LEFT;
            end else if (pending[1]) begin
                serve   = 4'b0010;
                btn_cmd = CMD_RIGHT;
            end else if (pending[2]) begin
                serve   = 4'b0100;
                btn_cmd = CMD_UP;
            end else if (pending[3]) begin
                serve   = 4'b1000;
                btn_cmd = CMD_DOWN;
            end
        end
    end

    // Remember button levels and latch one pending event per rising edge
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= '0;
            pending  <= '0;
        end else begin
            btn_prev <= btn_now;
            pending  <= (pending & ~serve) | btn_rise;
        end
    end

    // Resolve the single action for this cycle and compute the next page/item
    always_comb begin
        act      = uart_slot ? uart_cmd : btn_cmd;
        act_uart = uart_slot;
        page_nxt = page;
        item_nxt = item;
        src_nxt  = last_src;
        err_nxt  = ack_timeout;
        case (act)
            CMD_LEFT:  page_nxt = PW'(step_idx(int'(page), N_PAGE, 1'b0));
            CMD_RIGHT: page_nxt = PW'(step_idx(int'(page), N_PAGE, 1'b1));
            CMD_UP:    item_nxt = IW'(step_idx(int'(item), N_ITEM, 1'b0));
            CMD_DOWN:  item_nxt = IW'(step_idx(int'(item), N_ITEM, 1'b1));
            CMD_HOME: begin
                page_nxt = '0;
                item_nxt = '0;
            end
            CMD_PAGE:  page_nxt = PW'(digit_val);
            CMD_BAD:   err_nxt  = 1'b1;
            default: begin
            end
        endcase
        if (act != CMD_NONE && act != CMD_BAD) src_nxt = act_uart;
        if (page_nxt != page) item_nxt = '0;
    end

    // Register the menu state and the one-cycle error pulse
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            page     <= '0;
            item     <= '0;
            last_src <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            page     <= page_nxt;
            item     <= item_nxt;
            last_src <= src_nxt;
            cmd_err  <= err_nxt;
        end
    end

    // Retriggerable activity stretcher, reloaded on every captured byte
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            led_cnt <= '0;
        end else if (uart_slot) begin
            led_cnt <= LW'(LED_HOLD);
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - LW'(1);
        end
    end

    assign uart_act_led = (led_cnt != '0);

endmodule

// File: tb/tb_menu_cmd_controller.sv
// Directed testbench for menu_cmd_controller: one wrapping and one saturating instance.
module tb_menu_cmd_controller;

    localparam int ACK_TO   = 20;
    localparam int LED_HOLD = 30;

    logic       clk_1MHz = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic       rvalid_w = 1'b0, rvalid_s = 1'b0;
    logic [7:0] uart_rdata = 8'h00;

    logic       ren_w, err_w, led_w, src_w;
    logic [1:0] page_w, item_w;
    logic       ren_s, err_s, led_s, src_s;
    logic [1:0] page_s, item_s;

    logic       use_sat = 1'b0;
    logic       sel_ren, sel_err, sel_led;

    int checks = 0;
    int fails  = 0;
    int obs_err, obs_ren, obs_led, obs_err_rise;
    logic prev_ren;

    assign sel_ren = use_sat ? ren_s : ren_w;
    assign sel_err = use_sat ? err_s : err_w;
    assign sel_led = use_sat ? led_s : led_w;

    menu_cmd_controller #(
        .N_PAGE(4), .N_ITEM(4), .WRAP(1), .SYNC_STAGES(2),
        .ACK_TIMEOUT(ACK_TO), .LED_HOLD(LED_HOLD)
    ) dut_wrap (
        .clk_1MHz(clk_1MHz), .rst_n(rst_n),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .uart_rvalid(rvalid_w), .uart_rdata(uart_rdata), .uart_ren(ren_w),
        .page(page_w), .item(item_w), .cmd_err(err_w),
        .uart_act_led(led_w), .last_src(src_w)
    );

    menu_cmd_controller #(
        .N_PAGE(4), .N_ITEM(4), .WRAP(0), .SYNC_STAGES(2),
        .ACK_TIMEOUT(ACK_TO), .LED_HOLD(LED_HOLD)
    ) dut_sat (
        .clk_1MHz(clk_1MHz), .rst_n(rst_n),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .uart_rvalid(rvalid_s), .uart_rdata(uart_rdata), .uart_ren(ren_s),
        .page(page_s), .item(item_s), .cmd_err(err_s),
        .uart_act_led(led_s), .last_src(src_s)
    );

    // 1 MHz clock
    always #500 clk_1MHz = ~clk_1MHz;

    // Watchdog so the run always ends
    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_1MHz);
        #1;
        if (sel_err === 1'b1) obs_err++;
        if (sel_led === 1'b1) obs_led++;
        if (sel_ren === 1'b1 && prev_ren !== 1'b1) begin
            obs_ren++;
            if (sel_err === 1'b1) obs_err_rise++;
        end
        prev_ren = sel_ren;
    endtask

    task automatic clear_obs();
        obs_err = 0; obs_ren = 0; obs_led = 0; obs_err_rise = 0;
        prev_ren = sel_ren;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rvalid_w = 1'b0; rvalid_s = 1'b0;
        btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
        uart_rdata = 8'h00;
        repeat (2) @(posedge clk_1MHz);
        @(negedge clk_1MHz);
        rst_n = 1'b1;
        @(posedge clk_1MHz);
        #1;
        prev_ren = sel_ren;
    endtask

    task automatic drive_rvalid(input logic v);
        if (use_sat) rvalid_s = v;
        else rvalid_w = v;
    endtask

    // Full 4-phase byte transfer on the selected instance, observing pulses
    task automatic send_byte(input logic [7:0] b);
        int n;
        clear_obs();
        uart_rdata = b;
        drive_rvalid(1'b1);
        n = 0;
        while (sel_ren !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (sel_ren !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ren_rise byte=%h: got %b expected 1", b, sel_ren);
        end
        drive_rvalid(1'b0);
        n = 0;
        while (sel_ren !== 1'b0 && n < 40) begin tick(); n++; end
        checks++;
        if (sel_ren !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ren_fall byte=%h: got %b expected 0", b, sel_ren);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_1MHz);
        #1;
        checks++;
        if ({page_w, item_w, ren_w, err_w, led_w, src_w} !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_wrap: got %h expected 00", {page_w, item_w, ren_w, err_w, led_w, src_w});
        end
        checks++;
        if ({page_s, item_s, ren_s, err_s, led_s, src_s} !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_sat: got %h expected 00", {page_s, item_s, ren_s, err_s, led_s, src_s});
        end
        do_reset();
        repeat (3) tick();
        checks++;
        if ({page_w, item_w, ren_w, led_w} !== 6'h00) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got %h expected 00", {page_w, item_w, ren_w, led_w});
        end
        use_sat = 1'b0;
        uart_rdata = 8'h52;
        rvalid_w = 1'b1;
        n = 0;
        while (ren_w !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (ren_w !== 1'b1 || page_w !== 2'd1) begin
            fails++;
            $display("[TB] FAIL mid_ack_setup: got ren=%b page=%0d expected ren=1 page=1", ren_w, page_w);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ren_w !== 1'b0 || page_w !== 2'd0) begin
            fails++;
            $display("[TB] FAIL reset_drops_ren: got ren=%b page=%0d expected ren=0 page=0", ren_w, page_w);
        end
        @(posedge clk_1MHz);
        #1;
        checks++;
        if (ren_w !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ren_after_edge: got %b expected 0", ren_w);
        end
        rvalid_w = 1'b0;
        do_reset();
    endtask

    task automatic test_uart_sequence();
        do_reset();
        use_sat = 1'b0;
        send_byte(8'h52);
        checks++;
        if (page_w !== 2'd1 || item_w !== 2'd0 || obs_ren != 1) begin
            fails++;
            $display("[TB] FAIL seq_r1: got page=%0d item=%0d rens=%0d expected 1 0 1", page_w, item_w, obs_ren);
        end
        send_byte(8'h52);
        checks++;
        if (page_w !== 2'd2 || item_w !== 2'd0 || obs_ren != 1) begin
            fails++;
            $display("[TB] FAIL seq_r2: got page=%0d item=%0d rens=%0d expected 2 0 1", page_w, item_w, obs_ren);
        end
        send_byte(8'h44);
        checks++;
        if (page_w !== 2'd2 || item_w !== 2'd1 || src_w !== 1'b1 || obs_ren != 1 || obs_err != 0) begin
            fails++;
            $display("[TB] FAIL seq_d: got page=%0d item=%0d src=%b rens=%0d errs=%0d expected 2 1 1 1 0",
                     page_w, item_w, src_w, obs_ren, obs_err);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        use_sat = 1'b0;
        send_byte(8'h6C);
        checks++;
        if (page_w !== 2'd3 || obs_err != 0) begin
            fails++;
            $display("[TB] FAIL wrap_left: got page=%0d errs=%0d expected 3 0", page_w, obs_err);
        end
        send_byte(8'h55);
        checks++;
        if (page_w !== 2'd3 || item_w !== 2'd3) begin
            fails++;
            $display("[TB] FAIL wrap_up: got page=%0d item=%0d expected 3 3", page_w, item_w);
        end
        send_byte(8'h52);
        checks++;
        if (page_w !== 2'd0 || item_w !== 2'd0) begin
            fails++;
            $display("[TB] FAIL wrap_right_item_clear: got page=%0d item=%0d expected 0 0", page_w, item_w);
        end
        use_sat = 1'b1;
        send_byte(8'h4C);
        checks++;
        if (page_s !== 2'd0 || obs_err != 0 || obs_ren != 1) begin
            fails++;
            $display("[TB] FAIL sat_left: got page=%0d errs=%0d rens=%0d expected 0 0 1", page_s, obs_err, obs_ren);
        end
        send_byte(8'h72);
        send_byte(8'h33);
        send_byte(8'h52);
        checks++;
        if (page_s !== 2'd3 || obs_err != 0) begin
            fails++;
            $display("[TB] FAIL sat_right: got page=%0d errs=%0d expected 3 0", page_s, obs_err);
        end
        for (int i = 0; i < 4; i++) send_byte(8'h64);
        checks++;
        if (item_s !== 2'd3 || page_s !== 2'd3) begin
            fails++;
            $display("[TB] FAIL sat_down: got page=%0d item=%0d expected 3 3", page_s, item_s);
        end
        use_sat = 1'b0;
    endtask

    task automatic test_errors();
        do_reset();
        use_sat = 1'b0;
        send_byte(8'h32);
        send_byte(8'h64);
        checks++;
        if (page_w !== 2'd2 || item_w !== 2'd1 || obs_err != 0) begin
            fails++;
            $display("[TB] FAIL digit_two: got page=%0d item=%0d errs=%0d expected 2 1 0", page_w, item_w, obs_err);
        end
        send_byte(8'h37);
        checks++;
        if (obs_err != 1 || obs_err_rise != 1 || obs_ren != 1 || page_w !== 2'd2 || item_w !== 2'd1) begin
            fails++;
            $display("[TB] FAIL digit_range: got errs=%0d at_rise=%0d rens=%0d page=%0d item=%0d expected 1 1 1 2 1",
                     obs_err, obs_err_rise, obs_ren, page_w, item_w);
        end
        send_byte(8'h78);
        checks++;
        if (obs_err != 1 || obs_ren != 1 || page_w !== 2'd2 || item_w !== 2'd1) begin
            fails++;
            $display("[TB] FAIL bad_byte: got errs=%0d rens=%0d page=%0d item=%0d expected 1 1 2 1",
                     obs_err, obs_ren, page_w, item_w);
        end
        send_byte(8'h0D);
        checks++;
        if (obs_err != 0 || obs_ren != 1 || page_w !== 2'd2 || item_w !== 2'd1) begin
            fails++;
            $display("[TB] FAIL cr_silent: got errs=%0d rens=%0d page=%0d item=%0d expected 0 1 2 1",
                     obs_err, obs_ren, page_w, item_w);
        end
        send_byte(8'h68);
        checks++;
        if (page_w !== 2'd0 || item_w !== 2'd0 || obs_err != 0) begin
            fails++;
            $display("[TB] FAIL home: got page=%0d item=%0d errs=%0d expected 0 0 0", page_w, item_w, obs_err);
        end
        send_byte(8'h33);
        checks++;
        if (page_w !== 2'd3) begin
            fails++;
            $display("[TB] FAIL digit_three: got page=%0d expected 3", page_w);
        end
    endtask

    task automatic test_buttons();
        do_reset();
        use_sat = 1'b0;
        btn_r = 1'b1;
        repeat (6) tick();
        checks++;
        if (page_w !== 2'd1 || src_w !== 1'b0) begin
            fails++;
            $display("[TB] FAIL btn_hold_once: got page=%0d src=%b expected 1 0", page_w, src_w);
        end
        btn_r = 1'b0;
        btn_d = 1'b1;
        repeat (3) tick();
        btn_d = 1'b0;
        tick();
        checks++;
        if (item_w !== 2'd1) begin
            fails++;
            $display("[TB] FAIL btn_down: got item=%0d expected 1", item_w);
        end
        btn_l = 1'b1;
        btn_u = 1'b1;
        tick();
        checks++;
        if (page_w !== 2'd1 || item_w !== 2'd1) begin
            fails++;
            $display("[TB] FAIL btn_latency: got page=%0d item=%0d expected 1 1", page_w, item_w);
        end
        tick();
        checks++;
        if (page_w !== 2'd0 || item_w !== 2'd0) begin
            fails++;
            $display("[TB] FAIL btn_order_left: got page=%0d item=%0d expected 0 0", page_w, item_w);
        end
        tick();
        checks++;
        if (page_w !== 2'd0 || item_w !== 2'd3 || src_w !== 1'b0) begin
            fails++;
            $display("[TB] FAIL btn_order_up: got page=%0d item=%0d src=%b expected 0 3 0", page_w, item_w, src_w);
        end
        btn_l = 1'b0;
        btn_u = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        use_sat = 1'b0;
        clear_obs();
        uart_rdata = 8'h44;
        rvalid_w = 1'b1;
        repeat (3) tick();
        btn_r = 1'b1;
        tick();
        checks++;
        if (item_w !== 2'd1 || page_w !== 2'd0 || src_w !== 1'b1 || ren_w !== 1'b1) begin
            fails++;
            $display("[TB] FAIL arb_uart_first: got item=%0d page=%0d src=%b ren=%b expected 1 0 1 1",
                     item_w, page_w, src_w, ren_w);
        end
        tick();
        checks++;
        if (page_w !== 2'd1 || item_w !== 2'd0 || src_w !== 1'b0) begin
            fails++;
            $display("[TB] FAIL arb_button_next: got page=%0d item=%0d src=%b expected 1 0 0", page_w, item_w, src_w);
        end
        rvalid_w = 1'b0;
        n = 0;
        while (ren_w !== 1'b0 && n < 40) begin tick(); n++; end
        btn_r = 1'b0;
        repeat (3) tick();
        checks++;
        if (page_w !== 2'd1 || obs_ren != 1) begin
            fails++;
            $display("[TB] FAIL arb_settle: got page=%0d rens=%0d expected 1 1", page_w, obs_ren);
        end
    endtask

    task automatic test_timeout_led();
        int n;
        int ren_high;
        do_reset();
        use_sat = 1'b0;
        clear_obs();
        uart_rdata = 8'h52;
        rvalid_w = 1'b1;
        n = 0;
        ren_high = 0;
        while (err_w !== 1'b1 && n < ACK_TO + 40) begin
            tick();
            n++;
            if (ren_w === 1'b1) ren_high++;
        end
        checks++;
        if (err_w !== 1'b1 || ren_w !== 1'b0 || ren_high != ACK_TO) begin
            fails++;
            $display("[TB] FAIL ack_timeout: got err=%b ren=%b ren_cycles=%0d expected 1 0 %0d",
                     err_w, ren_w, ren_high, ACK_TO);
        end
        tick();
        checks++;
        if (err_w !== 1'b0) begin
            fails++;
            $display("[TB] FAIL timeout_pulse_width: got err=%b expected 0", err_w);
        end
        repeat (10) tick();
        checks++;
        if (obs_ren != 1 || ren_w !== 1'b0 || page_w !== 2'd1) begin
            fails++;
            $display("[TB] FAIL stuck_no_reaccept: got rens=%0d ren=%b page=%0d expected 1 0 1", obs_ren, ren_w, page_w);
        end
        rvalid_w = 1'b0;
        repeat (4) tick();
        send_byte(8'h52);
        checks++;
        if (page_w !== 2'd2 || obs_ren != 1) begin
            fails++;
            $display("[TB] FAIL rearm_after_timeout: got page=%0d rens=%0d expected 2 1", page_w, obs_ren);
        end
        do_reset();
        send_byte(8'h44);
        n = 0;
        while (led_w === 1'b1 && n < LED_HOLD + 20) begin tick(); n++; end
        checks++;
        if (led_w !== 1'b0 || obs_led != LED_HOLD) begin
            fails++;
            $display("[TB] FAIL led_hold: got led=%b high_cycles=%0d expected 0 %0d", led_w, obs_led, LED_HOLD);
        end
    endtask

    initial begin
        obs_err = 0; obs_ren = 0; obs_led = 0; obs_err_rise = 0;
        prev_ren = 1'b0;
        $display("[TB] menu_cmd_controller directed tests start");
        test_reset();
        test_uart_sequence();
        test_wrap();
        test_errors();
        test_buttons();
        test_back_to_back();
        test_timeout_led();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
